// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the CPU datapath (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [63:0] reqAddr;
  logic [1:0]  reqSize;
  logic [63:0] reqWData;
  logic        respValid;
  logic        respReady;
  logic [63:0] respRData;
  logic        respErr;

  modport master (
    output reqValid, reqWrite, reqAddr, reqSize, reqWData, respReady,
    input  reqReady, respValid, respRData, respErr
  );

  modport slave (
    input  reqValid, reqWrite, reqAddr, reqSize, reqWData, respReady,
    output reqReady, respValid, respRData, respErr
  );
endinterface

// File: rtl/dmem_responder.sv
// Little-endian 64-bit-word data memory that answers one load/store at a time
// after WAIT_CYCLES wait states, and mirrors the last stored word on dMemOut.
module dmem_responder #(
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  dmem_responder_if.slave   bus,
  output logic [63:0]       dMemOut
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_next;
  logic [7:0]  cnt, cnt_next;

  logic [63:0] addr_q;
  logic [1:0]  size_q;
  logic        write_q;
  logic [63:0] wdata_q;

  logic [63:0] mem [DEPTH];

  // In IDLE the live request is used directly so WAIT_CYCLES=0 can answer on the accept edge.
  logic [63:0] cur_addr;
  logic [1:0]  cur_size;
  logic        cur_write;
  logic [63:0] cur_wdata;
  logic        cur_err;
  logic [2:0]  align_mask;
  logic [63:0] size_mask;
  logic [63:0] lane_mask;
  logic [5:0]  lane_shift;
  logic [AW-1:0] word_idx;
  logic [63:0] old_word;
  logic [63:0] merged_word;
  logic [63:0] load_data;
  logic        accept;
  logic        enter_resp;
  logic        commit;

  assign bus.reqReady  = (state == IDLE);
  assign bus.respValid = (state == RESP);
  assign accept        = (state == IDLE) && bus.reqValid;

  assign cur_addr  = (state == IDLE) ? bus.reqAddr  : addr_q;
  assign cur_size  = (state == IDLE) ? bus.reqSize  : size_q;
  assign cur_write = (state == IDLE) ? bus.reqWrite : write_q;
  assign cur_wdata = (state == IDLE) ? bus.reqWData : wdata_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    align_mask = 3'b000;
    size_mask  = 64'h0000_0000_0000_00FF;
    case (cur_size)
      2'b00: begin align_mask = 3'b000; size_mask = 64'h0000_0000_0000_00FF; end
      2'b01: begin align_mask = 3'b001; size_mask = 64'h0000_0000_0000_FFFF; end
      2'b10: begin align_mask = 3'b011; size_mask = 64'h0000_0000_FFFF_FFFF; end
      default: begin align_mask = 3'b111; size_mask = 64'hFFFF_FFFF_FFFF_FFFF; end
    endcase
  end

  assign cur_err = ((cur_addr[2:0] & align_mask) != 3'b000) ||
                   ({3'b000, cur_addr[63:3]} >= 64'(DEPTH));

  assign lane_shift  = {cur_addr[2:0], 3'b000};
  assign lane_mask   = size_mask << lane_shift;
  assign word_idx    = cur_addr[AW+2:3];
  assign old_word    = mem[word_idx];
  assign merged_word = (old_word & ~lane_mask) | ((cur_wdata << lane_shift) & lane_mask);
  assign load_data   = (old_word >> lane_shift) & size_mask;

  assign enter_resp = ((state == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                      ((state == BUSY) && (cnt == 8'd0));
  assign commit     = enter_resp && cur_write && !cur_err && !Rst;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
          end else begin
            state_next = BUSY;
            cnt_next   = 8'(WAIT_CYCLES - 1);
          end
        end
      end
      BUSY: begin
        if (cnt == 8'd0) state_next = RESP;
        else             cnt_next   = cnt - 8'd1;
      end
      RESP: begin
        if (bus.respReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      addr_q        <= 64'd0;
      size_q        <= 2'b00;
      write_q       <= 1'b0;
      wdata_q       <= 64'd0;
      bus.respRData <= 64'd0;
      bus.respErr   <= 1'b0;
      dMemOut       <= 64'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        addr_q  <= bus.reqAddr;
        size_q  <= bus.reqSize;
        write_q <= bus.reqWrite;
        wdata_q <= bus.reqWData;
      end
      if (enter_resp) begin
        bus.respErr   <= cur_err;
        bus.respRData <= (cur_err || cur_write) ? 64'd0 : load_data;
        if (cur_write && !cur_err) dMemOut <= merged_word;
      end
    end
  end

  // NOTE: the array has no reset so it maps onto plain RAM and keeps stores across Rst.
  always_ff @(posedge Clk) begin
    if (commit) mem[word_idx] <= merged_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized bench for dmem_responder against a byte-array reference model.
module tb_dmem_responder;
  localparam int DEPTH = 32;
  localparam int W     = 2;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [63:0] dMemOut;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .bus     (bus),
    .dMemOut (dMemOut)
  );

  always #5 Clk = ~Clk;

  int compared   = 0;
  int mismatched = 0;

  byte unsigned ref_mem [DEPTH*8];
  logic [63:0]  ref_dmem;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [63:0] addr, input logic [1:0] size);
    return ((addr % (64'd1 << size)) != 64'd0) || ((addr / 64'd8) >= 64'(DEPTH));
  endfunction

  // Byte-level memory semantics; returns the expected load data.
  task automatic model_access(input logic write, input logic [63:0] addr, input logic [1:0] size,
                              input logic [63:0] wdata, output logic [63:0] rdata,
                              output logic err);
    int n, base;
    n     = 1 << size;
    err   = model_err(addr, size);
    rdata = 64'd0;
    if (err) return;
    if (write) begin
      for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
      base = int'(addr) & ~7;
      for (int i = 0; i < 8; i++) ref_dmem[8*i +: 8] = ref_mem[base + i];
    end else begin
      for (int i = 0; i < n; i++) rdata[8*i +: 8] = ref_mem[int'(addr) + i];
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic do_req(input string tag, input logic write, input logic [63:0] addr,
                        input logic [1:0] size, input logic [63:0] wdata, input int hold,
                        output logic [63:0] rdata_obs);
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          t, lat;
    bus.reqValid = 1'b1;
    bus.reqWrite = write;
    bus.reqAddr  = addr;
    bus.reqSize  = size;
    bus.reqWData = wdata;
    t = 0;
    while (!bus.reqReady && t < 50) begin
      @(negedge Clk);
      t++;
    end
    check({tag, "_ready"}, bus.reqReady, 1'b1);
    @(negedge Clk);
    bus.reqValid = 1'b0;
    bus.reqAddr  = {$urandom, $urandom};
    bus.reqWData = {$urandom, $urandom};
    bus.reqSize  = 2'($urandom);
    bus.reqWrite = 1'($urandom);
    lat = 1;
    while (!bus.respValid && lat < 300) begin
      @(negedge Clk);
      lat++;
    end
    check({tag, "_valid"}, bus.respValid, 1'b1);
    check({tag, "_latency"}, 64'(lat), 64'(W + 1));
    model_access(write, addr, size, wdata, exp_rdata, exp_err);
    rdata_obs = bus.respRData;
    check({tag, "_rdata"}, bus.respRData, exp_rdata);
    check({tag, "_err"}, bus.respErr, exp_err);
    check({tag, "_dmem"}, dMemOut, ref_dmem);
    for (int h = 0; h < hold; h++) begin
      bus.reqValid = 1'b1;
      @(negedge Clk);
      check({tag, "_hold_valid"}, bus.respValid, 1'b1);
      check({tag, "_hold_rdata"}, bus.respRData, exp_rdata);
      check({tag, "_hold_err"}, bus.respErr, exp_err);
      check({tag, "_hold_ready"}, bus.reqReady, 1'b0);
    end
    bus.reqValid  = 1'b0;
    bus.respReady = 1'b1;
    @(negedge Clk);
    bus.respReady = 1'b0;
    check({tag, "_done_valid"}, bus.respValid, 1'b0);
    check({tag, "_done_ready"}, bus.reqReady, 1'b1);
  endtask

  initial begin
    logic [63:0] rd, prior, a;
    logic [1:0]  sz;
    int          t;

    ref_dmem      = 64'd0;
    Rst           = 1'b1;
    bus.reqValid  = 1'b0;
    bus.reqWrite  = 1'b0;
    bus.reqAddr   = 64'd0;
    bus.reqSize   = 2'b00;
    bus.reqWData  = 64'd0;
    bus.respReady = 1'b0;

    // Reset state
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    check("rst_ready", bus.reqReady, 1'b1);
    check("rst_valid", bus.respValid, 1'b0);
    check("rst_dmem", dMemOut, 64'd0);
    check("rst_rdata", bus.respRData, 64'd0);
    check("rst_err", bus.respErr, 1'b0);

    // Basic store/load
    do_req("st_dw", 1'b1, 64'h10, 2'b11, 64'h2, 0, rd);
    check("st_dw_dmem_const", dMemOut, 64'h2);
    do_req("ld_dw", 1'b0, 64'h10, 2'b11, 64'h0, 0, rd);
    check("ld_dw_const", rd, 64'h2);

    // Byte-lane merge
    do_req("st_full", 1'b1, 64'h8, 2'b11, 64'h1122334455667788, 0, rd);
    do_req("st_byte", 1'b1, 64'hB, 2'b00, 64'hAB, 0, rd);
    check("st_byte_dmem_const", dMemOut, 64'h11223344AB667788);
    do_req("ld_word", 1'b0, 64'h8, 2'b10, 64'h0, 0, rd);
    check("ld_word_const", rd, 64'h00000000AB667788);

    // Errors: misaligned and out of range
    do_req("err_mis", 1'b0, 64'h3, 2'b01, 64'h0, 0, rd);
    do_req("err_oor", 1'b0, 64'(8 * DEPTH), 2'b11, 64'h0, 0, rd);
    do_req("err_st_oor", 1'b1, 64'(8 * DEPTH) + 64'h8, 2'b11, 64'hDEAD, 0, rd);
    check("err_dmem_const", dMemOut, 64'h11223344AB667788);

    // Back-pressure with a competing request held on the bus
    do_req("hold", 1'b0, 64'h8, 2'b11, 64'h0, 5, rd);

    // Reset during BUSY aborts the store
    prior = 64'hCAFE_F00D_0123_4567;
    do_req("st_prior", 1'b1, 64'h18, 2'b11, prior, 0, rd);
    bus.reqValid = 1'b1;
    bus.reqWrite = 1'b1;
    bus.reqAddr  = 64'h18;
    bus.reqSize  = 2'b11;
    bus.reqWData = 64'hFF;
    @(negedge Clk);
    bus.reqValid = 1'b0;
    check("abort_busy_ready", bus.reqReady, 1'b0);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    ref_dmem = 64'd0;
    @(negedge Clk);
    check("abort_dmem", dMemOut, 64'd0);
    check("abort_ready", bus.reqReady, 1'b1);
    check("abort_valid", bus.respValid, 1'b0);
    do_req("ld_after_abort", 1'b0, 64'h18, 2'b11, 64'h0, 0, rd);
    check("ld_after_abort_const", rd, prior);

    // Fill every word, then random traffic
    for (int i = 0; i < DEPTH; i++)
      do_req("fill", 1'b1, 64'(8 * i), 2'b11, {$urandom, $urandom}, 0, rd);
    for (int i = 0; i < 80; i++) begin
      sz = 2'($urandom);
      t  = int'($urandom_range(0, 15));
      if (t == 0)      a = {$urandom, $urandom} | 64'h1_0000_0000;
      else if (t == 1) a = 64'(8 * DEPTH) + 64'($urandom_range(0, 63));
      else if (t < 5)  a = 64'($urandom_range(0, 8 * DEPTH - 1));
      else             a = 64'($urandom_range(0, 8 * DEPTH - 1)) & ~((64'd1 << sz) - 64'd1);
      do_req("rand", 1'($urandom), a, sz, {$urandom, $urandom}, int'($urandom_range(0, 2)), rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
